// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - data RAM plus memory-mapped result FIFO and run control for a CPU (optional DMEM_MISALIGN_CHK_EN)
module dmem_io_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        start,
    input  logic        host_go,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        ovf,
    output logic        err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  FULL_CNT  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state;
    logic [31:0]    ram [DEPTH_WORDS];
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [3:0]     count;

    // Decode works on the word address; the byte offset never selects a target
    logic [31:0]    word_addr;
    logic           is_ram;
    logic           is_res;
    logic           is_ctl;
    logic [AW-1:0]  ram_idx;
    logic           wr_ok;
    logic           ram_we;
    logic           ctl_wr;
    logic           push_req;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           drop;

    assign word_addr = {ALUResult[31:2], 2'b00};
    assign is_ram    = ALUResult < RAM_BYTES;
    assign is_res    = word_addr == IO_BASE;
    assign is_ctl    = word_addr == (IO_BASE + 32'd4);
    assign ram_idx   = ALUResult[AW+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
    logic misalign_wr;
    logic err_q;
    assign misalign_wr = MemWrite && (ALUResult[1:0] != 2'b00);
    assign wr_ok       = MemWrite && !misalign_wr;
    assign err         = err_q;
`else
    assign wr_ok       = MemWrite;
    assign err         = 1'b0;
`endif

    assign ram_we    = wr_ok && is_ram;
    assign ctl_wr    = wr_ok && is_ctl;
    assign push_req  = wr_ok && is_res && (state == RUN);
    assign full      = count == FULL_CNT;
    assign out_valid = count != 4'd0;
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // Zero-latency load path; unmapped addresses read as zero
    always_comb begin
        ReadData = 32'd0;
        if (is_ram)
            ReadData = ram[ram_idx];
        else if (is_res)
            ReadData = {27'd0, ovf, count};
        else if (is_ctl)
            ReadData = {30'd0, err, busy};
    end

    // Data RAM store port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= WriteData;
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= WriteData;
    end

    // FIFO pointers and occupancy; reset discards every queued entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Run control FSM with registered start/busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (host_go) begin
                    state <= RUN;
                    start <= 1'b1;
                    busy  <= 1'b1;
                end
                RUN: if (ctl_wr) begin
                    state <= DRAIN;
                    start <= 1'b0;
                end
                DRAIN: if (count == 4'd0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a CTL write while idle acknowledges it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (ctl_wr && (state == IDLE))
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
    end

`ifdef DMEM_MISALIGN_CHK_EN
    // Sticky misaligned-write flag, cleared like ovf
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (misalign_wr)
            err_q <= 1'b1;
        else if (ctl_wr && (state == IDLE))
            err_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_dmem_io_responder.sv
// tb/tb_dmem_io_responder.sv - directed self-checking bench for dmem_io_responder
module tb_dmem_io_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        start;
    logic        host_go;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        ovf;
    logic        err;

    int checks;
    int failures;

    localparam logic [31:0] RES = 32'h0000_1000;
    localparam logic [31:0] CTL = 32'h0000_1004;

    dmem_io_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .start     (start),
        .host_go   (host_go),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        ALUResult = addr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic go_pulse();
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
        ALUResult = addr;
        #1;
        data = ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({start, busy, out_valid, ovf, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {start, busy, out_valid, ovf, err});
        end
        read_word(RES, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reset_res got=%h want=00000000", rd);
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        write_word(32'h10, 32'hDEAD_BEEF);
        read_word(32'h10, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_read_0x10 got=%h want=deadbeef", rd);
        end
        read_word(32'h2000, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read got=%h want=00000000", rd);
        end
        write_word(32'h3FC, 32'h1234_5678);
        read_word(32'h3FC, rd);
        checks++;
        if (rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL ram_last_word got=%h want=12345678", rd);
        end
        read_word(32'h400, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL ram_past_end got=%h want=00000000", rd);
        end
    endtask

    task automatic test_run();
        logic [31:0] rd;
        go_pulse();
        checks++;
        if ({start, busy} !== 2'b11) begin
            failures++;
            $display("FAIL run_start got=%b want=11", {start, busy});
        end
        write_word(RES, 32'h5);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5) begin
            failures++;
            $display("FAIL run_push got=%b/%h want=1/00000005", out_valid, out_data);
        end
        go_pulse();
        checks++;
        if ({start, busy} !== 2'b11) begin
            failures++;
            $display("FAIL run_go_ignored got=%b want=11", {start, busy});
        end
        write_word(CTL, 32'h0);
        checks++;
        if ({start, busy} !== 2'b01) begin
            failures++;
            $display("FAIL run_to_drain got=%b want=01", {start, busy});
        end
        go_pulse();
        write_word(RES, 32'h7);
        read_word(RES, rd);
        checks++;
        if ({start, busy} !== 2'b01 || rd !== 32'h1) begin
            failures++;
            $display("FAIL drain_ignores got=%b/%h want=01/00000001", {start, busy}, rd);
        end
        read_word(CTL, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL ctl_read_drain got=%h want=00000001", rd);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_pop got=%b want=0", out_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [31:0] exp_q[$];
        go_pulse();
        for (int i = 0; i < 9; i++)
            write_word(RES, 32'h100 + 32'(i));
        for (int i = 1; i < 8; i++)
            exp_q.push_back(32'h100 + 32'(i));
        exp_q.push_back(32'h200);
        read_word(RES, rd);
        checks++;
        if (rd !== 32'h18 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full got=%h/%b want=00000018/1", rd, ovf);
        end
        checks++;
        if (out_data !== 32'h100) begin
            failures++;
            $display("FAIL ovf_head got=%h want=00000100", out_data);
        end
        out_ready = 1'b1;
        write_word(RES, 32'h200);
        out_ready = 1'b0;
        read_word(RES, rd);
        checks++;
        if (rd !== 32'h18) begin
            failures++;
            $display("FAIL full_push_pop got=%h want=00000018", rd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                failures++;
                $display("FAIL fifo_order[%0d] got=%b/%h want=1/%h", i, out_valid, out_data, exp_q[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_empty got=%b want=0", out_valid);
        end
        write_word(CTL, 32'h0);
        tick();
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b/%b want=0/1", busy, ovf);
        end
        write_word(CTL, 32'h0);
        checks++;
        if (ovf !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b/%b want=0/0", ovf, busy);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] rd;
        write_word(32'h20, 32'hCAFE_F00D);
        go_pulse();
        for (int i = 0; i < 3; i++)
            write_word(RES, 32'h30 + 32'(i));
        read_word(RES, rd);
        checks++;
        if (rd !== 32'h3) begin
            failures++;
            $display("FAIL midrun_queued got=%h want=00000003", rd);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, start, busy} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_async got=%b want=000", {out_valid, start, busy});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({out_valid, start, busy} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_after got=%b want=000", {out_valid, start, busy});
        end
        read_word(32'h20, rd);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL midrun_ram got=%h want=cafef00d", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        write_word(32'h11, 32'hA5A5_A5A5);
        read_word(32'h10, rd);
`ifdef DMEM_MISALIGN_CHK_EN
        checks++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b1) begin
            failures++;
            $display("FAIL misalign_chk got=%h/%b want=deadbeef/1", rd, err);
        end
        write_word(CTL, 32'h0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_clear got=%b want=0", err);
        end
`else
        checks++;
        if (rd !== 32'hA5A5_A5A5 || err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_nochk got=%h/%b want=a5a5a5a5/0", rd, err);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        host_go   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_ram();
        test_run();
        test_overflow();
        test_reset_midrun();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
